// File: rtl/param_alu_pipeline.sv
// param_alu_pipeline: three-stage (FETCH/EXECUTE/GENPAR) one-hot-coded ALU with
// valid/ready flow control and result parity. Revision 1.0.
`default_nettype none

module param_alu_pipeline #(
  parameter int WIDTH      = 32,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             parity,
  output logic             code_err
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOP  = 4'd3;
  localparam logic [3:0] OP_ANDN = 4'd4;
  localparam logic [3:0] OP_ORN  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_LSL  = 4'd10;
  localparam logic [3:0] OP_LSR  = 4'd11;
  localparam logic [3:0] OP_SAT  = 4'd12;
  localparam logic [3:0] OP_ASR  = 4'd13;
  localparam logic [3:0] OP_ROL  = 4'd14;
  localparam logic [3:0] OP_ROR  = 4'd15;

  // Whole pipeline moves as one unit; it only freezes when the output is blocked.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Opcode decode: the bit index of a one-hot code is the op number.
  logic [3:0] dec_op;
  logic       dec_err;
  always_comb begin
    dec_op  = OP_NOP;
    dec_err = 1'b1;
    if ((code != 16'd0) && ((code & (code - 16'd1)) == 16'd0)) begin
      dec_err = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (code[i]) dec_op = 4'(i);
      end
    end
  end

  // FETCH stage
  logic             f_valid;
  logic [WIDTH-1:0] f_a;
  logic [WIDTH-1:0] f_b;
  logic [3:0]       f_op;
  logic             f_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      f_valid <= 1'b0;
      f_a     <= '0;
      f_b     <= '0;
      f_op    <= OP_NOP;
      f_err   <= 1'b0;
    end else if (advance) begin
      f_valid <= in_valid;
      f_a     <= A;
      f_b     <= B;
      f_op    <= dec_op;
      f_err   <= dec_err;
    end
  end

  // ALU datapath on FETCH contents
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;

  assign sum  = {1'b0, f_a} + {1'b0, f_b};
  assign diff = {1'b0, f_a} - {1'b0, f_b};

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    case (f_op)
      OP_AND:  alu_res = f_a & f_b;
      OP_OR:   alu_res = f_a | f_b;
      OP_ADD:  {alu_cout, alu_res} = sum;
      OP_NOP:  alu_res = '0;
      OP_ANDN: alu_res = f_a & ~f_b;
      OP_ORN:  alu_res = f_a | ~f_b;
      OP_SUB:  {alu_cout, alu_res} = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      OP_XOR:  alu_res = f_a ^ f_b;
      OP_XNOR: alu_res = ~(f_a ^ f_b);
      OP_LSL:  alu_res = {f_a[WIDTH-2:0], 1'b0};
      OP_LSR:  alu_res = {1'b0, f_a[WIDTH-1:1]};
      OP_SAT: begin
        alu_cout = sum[WIDTH];
        alu_res  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      end
      OP_ASR:  alu_res = {f_a[WIDTH-1], f_a[WIDTH-1:1]};
      OP_ROL:  alu_res = {f_a[WIDTH-2:0], f_a[WIDTH-1]};
      OP_ROR:  alu_res = {f_a[0], f_a[WIDTH-1:1]};
      default: alu_res = '0;
    endcase
  end

  // EXECUTE stage
  logic             e_valid;
  logic [WIDTH-1:0] e_result;
  logic             e_cout;
  logic             e_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_valid  <= 1'b0;
      e_result <= '0;
      e_cout   <= 1'b0;
      e_err    <= 1'b0;
    end else if (advance) begin
      e_valid  <= f_valid;
      e_result <= alu_res;
      e_cout   <= alu_cout;
      e_err    <= f_err;
    end
  end

  // GENPAR stage drives the outputs directly from registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      parity    <= PARITY_ODD;
      code_err  <= 1'b0;
    end else if (advance) begin
      out_valid <= e_valid;
      result    <= e_result;
      cout      <= e_cout;
      parity    <= (^e_result) ^ PARITY_ODD;
      code_err  <= e_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_alu_pipeline.sv
// Testbench for param_alu_pipeline: directed and random beats against a scoreboard
// model, on a WIDTH=32 even-parity instance and a WIDTH=8 odd-parity instance.
`default_nettype none

module tb_param_alu_pipeline;

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        par;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] code;
  logic [31:0] a;
  logic [31:0] b;

  logic        in_ready,  out_valid,  cout,  parity,  code_err;
  logic [31:0] result;
  logic        in_ready8, out_valid8, cout8, parity8, code_err8;
  logic [7:0]  result8;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  param_alu_pipeline #(.WIDTH(32), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code(code),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .parity(parity), .code_err(code_err)
  );

  param_alu_pipeline #(.WIDTH(8), .PARITY_ODD(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .code(code),
    .A(a[7:0]), .B(b[7:0]), .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
    .cout(cout8), .parity(parity8), .code_err(code_err8)
  );

  function automatic exp_t model(input logic [15:0] c, input logic [63:0] ai, input logic [63:0] bi,
                                 input int w, input bit podd);
    exp_t e;
    logic [64:0] mask, x, y, s, r;
    mask   = (65'd1 << w) - 65'd1;
    x      = {1'b0, ai} & mask;
    y      = {1'b0, bi} & mask;
    s      = x + y;
    r      = '0;
    e.cout = 1'b0;
    e.err  = 1'b0;
    case (c)
      16'h0001: r = x & y;
      16'h0002: r = x | y;
      16'h0004: begin r = s; e.cout = s[w]; end
      16'h0008: r = '0;
      16'h0010: r = x & ~y;
      16'h0020: r = x | ~y;
      16'h0040: begin r = x - y; e.cout = (x < y); end
      16'h0080: r = (x < y) ? 65'd1 : 65'd0;
      16'h0100: r = x ^ y;
      16'h0200: r = ~(x ^ y);
      16'h0400: r = x << 1;
      16'h0800: r = x >> 1;
      16'h1000: begin e.cout = s[w]; r = s[w] ? mask : s; end
      16'h2000: r = (x >> 1) | (x[w-1] ? (65'd1 << (w - 1)) : 65'd0);
      16'h4000: r = (x << 1) | (x >> (w - 1));
      16'h8000: r = (x >> 1) | ((x & 65'd1) << (w - 1));
      default:  begin r = '0; e.err = 1'b1; end
    endcase
    r     = r & mask;
    e.res = r[63:0];
    e.par = (^r) ^ podd;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score output transfers and input acceptances, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (out_valid && out_ready) begin
        if (q32.size() == 0) check("unexpected_beat32", {63'd0, out_valid}, 64'd0);
        else begin
          e = q32.pop_front();
          check("res32", {32'd0, result}, e.res);
          check("cout32", {63'd0, cout}, {63'd0, e.cout});
          check("par32", {63'd0, parity}, {63'd0, e.par});
          check("err32", {63'd0, code_err}, {63'd0, e.err});
        end
      end
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) check("unexpected_beat8", {63'd0, out_valid8}, 64'd0);
        else begin
          e = q8.pop_front();
          check("res8", {56'd0, result8}, e.res);
          check("cout8", {63'd0, cout8}, {63'd0, e.cout});
          check("par8", {63'd0, parity8}, {63'd0, e.par});
          check("err8", {63'd0, code_err8}, {63'd0, e.err});
        end
      end
      if (in_valid && in_ready)  q32.push_back(model(code, {32'd0, a}, {32'd0, b}, 32, 1'b0));
      if (in_valid && in_ready8) q8.push_back(model(code, {32'd0, a}, {32'd0, b}, 8, 1'b1));
    end else begin
      q32.delete();
      q8.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    if ($urandom_range(0, 9) < 8) code = 16'd1 << $urandom_range(0, 15);
    else code = 16'($urandom);
    a = $urandom;
    b = ($urandom_range(0, 7) == 0) ? a : $urandom;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; code = 16'h0004; a = 32'd5; b = 32'd6;
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_code_err", {63'd0, code_err}, 64'd0);
    check("rst_parity", {63'd0, parity}, 64'd0);
    check("rst_parity8", {63'd0, parity8}, 64'd1);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_no_beat", {63'd0, out_valid}, 64'd0);

    // ADD overflow, latency of three edges
    code = 16'h0004; a = 32'hFFFF_FFFF; b = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("lat_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("add_res", {32'd0, result}, 64'd0);
    check("add_cout", {63'd0, cout}, 64'd1);
    check("add_par", {63'd0, parity}, 64'd0);
    check("add_err", {63'd0, code_err}, 64'd0);
    check("add8_res", {56'd0, result8}, 64'd0);
    check("add8_cout", {63'd0, cout8}, 64'd1);
    check("add8_par", {63'd0, parity8}, 64'd1);
    tick();

    // SAT on both widths
    code = 16'h1000; a = 32'hF000_0000; b = 32'h2000_0000; in_valid = 1'b1;
    tick();
    a = 32'h0000_00F0; b = 32'h0000_0020;
    tick();
    in_valid = 1'b0;
    tick();
    check("sat_res", {32'd0, result}, 64'hFFFF_FFFF);
    check("sat_cout", {63'd0, cout}, 64'd1);
    check("sat_par", {63'd0, parity}, 64'd0);
    tick();
    check("sat8_res", {56'd0, result8}, 64'hFF);
    check("sat8_cout", {63'd0, cout8}, 64'd1);
    check("sat8_par", {63'd0, parity8}, 64'd1);
    tick();

    // Back-to-back ADD, SUB, ASR
    in_valid = 1'b1;
    code = 16'h0004; a = 32'h1234_5678; b = 32'h1111_1111;
    tick();
    code = 16'h0040; a = 32'd1; b = 32'd2;
    tick();
    code = 16'h2000; a = 32'h8000_0000; b = 32'd0;
    tick();
    in_valid = 1'b0;
    check("b2b_add", {32'd0, result}, 64'h2345_6789);
    check("b2b_add_cout", {63'd0, cout}, 64'd0);
    tick();
    check("b2b_sub", {32'd0, result}, 64'hFFFF_FFFF);
    check("b2b_sub_cout", {63'd0, cout}, 64'd1);
    tick();
    check("b2b_asr", {32'd0, result}, 64'hC000_0000);
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    tick();

    // Illegal codes
    in_valid = 1'b1; code = 16'h0003; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    tick();
    code = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    check("err3_res", {32'd0, result}, 64'd0);
    check("err3_cout", {63'd0, cout}, 64'd0);
    check("err3_flag", {63'd0, code_err}, 64'd1);
    tick();
    check("err0_res", {32'd0, result}, 64'd0);
    check("err0_flag", {63'd0, code_err}, 64'd1);
    tick();
    tick();

    // Output stall with beats offered every cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      rand_beat();
      tick();
    end
    check("stall_hold", {32'd0, result}, q32[0].res);
    check("stall_depth", 64'(q32.size()), 64'd3);
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("stall_drain", 64'(q32.size()), 64'd0);

    // Reset with beats in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      tick();
    end
    rst = 1'b0;
    rand_beat();
    tick();
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_valid8", {63'd0, out_valid8}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_stale", {63'd0, out_valid}, 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("final_drain32", 64'(q32.size()), 64'd0);
    check("final_drain8", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
